// File: rtl/time_ctrl_pkg.sv
// Shared types and limits for the time controller: FSM state encoding,
// BCD roll-over limits and a two-digit BCD increment helper.
package time_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int SECS_MAX  = 59;

  // Two BCD digits, tens in the upper nibble.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // True when the BCD pair equals max_val.
  function automatic logic bcd2_at_max(input bcd2_t v, input int max_val);
    return (v.tens == 4'(max_val / 10)) && (v.units == 4'(max_val % 10));
  endfunction

  // Increment a BCD pair, wrapping max_val -> 00.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input int max_val);
    bcd2_t r;
    if (bcd2_at_max(v, max_val)) begin
      r = '0;
    end else if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_controller_if.sv
// Button requests and clock display bundle of the time controller.
// The master side drives the buttons and watches the display; the
// slave side is the controller.
interface time_controller_if;
  logic       h_button;
  logic       m_button;
  logic       s_button;
  logic [3:0] hours1;
  logic [3:0] hours2;
  logic [3:0] mins1;
  logic [3:0] mins2;
  logic [5:0] secs;
  logic       sec_pulse;
  logic       set_mode;

  modport master (
    output h_button, m_button, s_button,
    input  hours1, hours2, mins1, mins2, secs, sec_pulse, set_mode
  );

  modport slave (
    input  h_button, m_button, s_button,
    output hours1, hours2, mins1, mins2, secs, sec_pulse, set_mode
  );
endinterface

// File: rtl/time_controller_rise_detect.sv
// One-bit registered rising-edge detector. The detector stays disarmed for
// the first clock after reset release, so a level already high at release
// is absorbed as "previous" and only a later fall-then-rise yields an event.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;

  // Remember last level and arm the detector one cycle after reset.
  // NOTE: sequential state uses non-blocking assignments and the
  // asynchronous reset sits in the sensitivity list, so every flop
  // updates together and clears immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/time_controller.sv
// 24-hour BCD clock with a one-second prescaler and a RUN/SET mode FSM.
// Buttons arrive as debounced levels; each rising edge is one request.
// Any button event in a tick cycle drops that tick.
module time_controller
  import time_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       Reset,
  input  logic       HButton,
  input  logic       MButton,
  input  logic       SButton,
  output logic [3:0] hours1,
  output logic [3:0] hours2,
  output logic [3:0] mins1,
  output logic [3:0] mins2,
  output logic [5:0] secs,
  output logic       sec_pulse,
  output logic       set_mode
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic          w_h_evt;
  logic          w_m_evt;
  logic          w_s_evt;
  logic          w_any_evt;
  logic          w_tick;
  logic          w_adv;
  logic          w_sec_wrap;
  logic          w_min_wrap;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  bcd2_t         r_hours;
  bcd2_t         w_hours_nxt;
  bcd2_t         r_mins;
  bcd2_t         w_mins_nxt;
  logic [5:0]    r_secs;
  logic [5:0]    w_secs_nxt;
  logic          r_sec_pulse;

  rise_detect u_h_rise (.clk(CLK100MHZ), .rst_n(Reset), .i_level(HButton), .o_rise(w_h_evt));
  rise_detect u_m_rise (.clk(CLK100MHZ), .rst_n(Reset), .i_level(MButton), .o_rise(w_m_evt));
  rise_detect u_s_rise (.clk(CLK100MHZ), .rst_n(Reset), .i_level(SButton), .o_rise(w_s_evt));

  assign w_any_evt  = w_h_evt | w_m_evt | w_s_evt;
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_adv      = w_tick && (r_state == ST_RUN) && !w_any_evt;
  assign w_sec_wrap = w_adv && (r_secs == 6'(SECS_MAX));
  assign w_min_wrap = w_sec_wrap && bcd2_at_max(r_mins, MINS_MAX);

  // Mode FSM next state: only a set-button event toggles RUN <-> SET.
  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (w_s_evt) begin
      w_state_nxt = (r_state == ST_RUN) ? ST_SET : ST_RUN;
    end
  end

  // Next values of prescaler and time digits.
  always_comb begin
    w_presc_nxt = r_presc + 1'b1;
    w_secs_nxt  = r_secs;
    w_mins_nxt  = r_mins;
    w_hours_nxt = r_hours;

    // Mode change, minute set, SET mode and wrap all restart the second.
    if (w_s_evt || w_m_evt || (r_state == ST_SET) || w_tick) begin
      w_presc_nxt = '0;
    end

    if (w_s_evt || w_m_evt) begin
      w_secs_nxt = '0;
    end else if (w_adv) begin
      w_secs_nxt = w_sec_wrap ? 6'd0 : r_secs + 6'd1;
    end

    // Minute button and seconds carry are mutually exclusive (an event drops the tick).
    if (w_m_evt || w_sec_wrap) begin
      w_mins_nxt = bcd2_inc(r_mins, MINS_MAX);
    end

    if (w_h_evt || w_min_wrap) begin
      w_hours_nxt = bcd2_inc(r_hours, HOURS_MAX);
    end
  end

  // State, prescaler and time registers.
  always_ff @(posedge CLK100MHZ or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_RUN;
      r_presc     <= '0;
      r_hours     <= '0;
      r_mins      <= '0;
      r_secs      <= '0;
      r_sec_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_hours     <= w_hours_nxt;
      r_mins      <= w_mins_nxt;
      r_secs      <= w_secs_nxt;
      r_sec_pulse <= w_adv;
    end
  end

  assign hours1    = r_hours.tens;
  assign hours2    = r_hours.units;
  assign mins1     = r_mins.tens;
  assign mins2     = r_mins.units;
  assign secs      = r_secs;
  assign sec_pulse = r_sec_pulse;
  assign set_mode  = (r_state == ST_SET);

endmodule

// File: tb/tb_time_controller.sv
// Directed bench for time_controller with TICK_DIV=4. Inputs are driven and
// outputs sampled on the falling clock edge; expected times are hand-derived.
module tb_time_controller;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   pulse_cnt = 0;
  int   p_snap;

  time_controller_if u_if ();

  time_controller #(.TICK_DIV(TICK_DIV)) u_dut (
    .CLK100MHZ (clk),
    .Reset     (rst_n),
    .HButton   (u_if.h_button),
    .MButton   (u_if.m_button),
    .SButton   (u_if.s_button),
    .hours1    (u_if.hours1),
    .hours2    (u_if.hours2),
    .mins1     (u_if.mins1),
    .mins2     (u_if.mins2),
    .secs      (u_if.secs),
    .sec_pulse (u_if.sec_pulse),
    .set_mode  (u_if.set_mode)
  );

  always #5 clk = ~clk;

  // Count sec_pulse cycles; sampled at the rising edge before outputs update.
  always @(posedge clk) begin
    if (u_if.sec_pulse === 1'b1) pulse_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {10'd0, u_if.hours1, u_if.hours2, u_if.mins1, u_if.mins2, u_if.secs};
    exp = {10'd0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s)};
    check(tag, obs, exp);
  endtask

  task automatic press_h(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.h_button = 1'b1; step(1);
      u_if.h_button = 1'b0; step(1);
    end
  endtask

  task automatic press_m(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.m_button = 1'b1; step(1);
      u_if.m_button = 1'b0; step(1);
    end
  endtask

  // Event lands on the next rising edge; returns just after it.
  task automatic press_s();
    u_if.s_button = 1'b1; step(1);
    u_if.s_button = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    u_if.h_button = 1'b0;
    u_if.m_button = 1'b0;
    u_if.s_button = 1'b0;
    step(3);
    check_time("reset_time", 0, 0, 0);
    check("reset_pulse", 32'(u_if.sec_pulse), 32'd0);
    check("reset_mode", 32'(u_if.set_mode), 32'd0);

    // Free run from release: tick every 4 cycles.
    rst_n  = 1'b1;
    p_snap = pulse_cnt;
    step(3);
    check_time("run_3", 0, 0, 0);
    check("run_3_pulse", 32'(u_if.sec_pulse), 32'd0);
    step(1);
    check_time("run_4", 0, 0, 1);
    check("run_4_pulse", 32'(u_if.sec_pulse), 32'd1);
    step(1);
    check("run_5_pulse", 32'(u_if.sec_pulse), 32'd0);
    step(231);
    check_time("run_236", 0, 0, 59);
    step(4);
    check_time("run_240", 0, 1, 0);
    check("run_240_pulse", 32'(u_if.sec_pulse), 32'd1);
    check("run_pulse_count", 32'(pulse_cnt - p_snap), 32'd59);
    step(6);
    check_time("run_246", 0, 1, 1);

    // Enter SET with S held 3 cycles: one toggle, secs cleared.
    u_if.s_button = 1'b1;
    step(1);
    check("set_enter_mode", 32'(u_if.set_mode), 32'd1);
    check_time("set_enter_time", 0, 1, 0);
    step(2);
    u_if.s_button = 1'b0;
    check("set_held_mode", 32'(u_if.set_mode), 32'd1);
    step(1);
    press_h(23);
    check_time("set_h23", 23, 1, 0);
    u_if.h_button = 1'b1;
    step(20);
    u_if.h_button = 1'b0;
    step(1);
    check_time("h_held_wrap", 0, 1, 0);
    press_h(23);
    press_m(58);
    check_time("preload", 23, 59, 0);
    p_snap = pulse_cnt;
    step(40);
    check_time("set_frozen", 23, 59, 0);
    check("set_frozen_mode", 32'(u_if.set_mode), 32'd1);
    check("set_no_pulse", 32'(pulse_cnt - p_snap), 32'd0);

    // Back to RUN: first pulse 4 cycles later, then full day roll-over.
    press_s();
    check("run_again_mode", 32'(u_if.set_mode), 32'd0);
    step(3);
    check_time("exit_3", 23, 59, 0);
    check("exit_3_pulse", 32'(u_if.sec_pulse), 32'd0);
    step(1);
    check_time("exit_4", 23, 59, 1);
    check("exit_4_pulse", 32'(u_if.sec_pulse), 32'd1);
    step(232);
    check_time("pre_rollover", 23, 59, 59);
    step(4);
    check_time("rollover", 0, 0, 0);
    check("rollover_pulse", 32'(u_if.sec_pulse), 32'd1);

    // 12:59 minute press in RUN: 12:00, secs and prescaler cleared.
    press_s();
    step(1);
    press_h(12);
    press_m(59);
    check_time("preload_1259", 12, 59, 0);
    press_s();
    step(9);
    check_time("run_1259", 12, 59, 2);
    u_if.m_button = 1'b1;
    step(1);
    u_if.m_button = 1'b0;
    check_time("m_wrap", 12, 0, 0);
    check("m_wrap_pulse", 32'(u_if.sec_pulse), 32'd0);
    step(3);
    check_time("m_presc_3", 12, 0, 0);
    step(1);
    check_time("m_presc_4", 12, 0, 1);

    // H and M together in a tick cycle at 10:20:05.
    press_s();
    step(1);
    press_h(22);
    press_m(20);
    check_time("preload_1020", 10, 20, 0);
    press_s();
    step(20);
    check_time("run_1020", 10, 20, 5);
    step(3);
    check_time("pre_coincide", 10, 20, 5);
    u_if.h_button = 1'b1;
    u_if.m_button = 1'b1;
    step(1);
    u_if.h_button = 1'b0;
    u_if.m_button = 1'b0;
    check_time("coincide", 11, 21, 0);
    check("coincide_pulse", 32'(u_if.sec_pulse), 32'd0);

    // Reset mid-count at 05:30:17 with H held through release.
    press_s();
    step(1);
    press_h(18);
    press_m(9);
    check_time("preload_0530", 5, 30, 0);
    press_s();
    step(70);
    check_time("run_0530", 5, 30, 17);
    u_if.h_button = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_time("async_reset_time", 0, 0, 0);
    check("async_reset_pulse", 32'(u_if.sec_pulse), 32'd0);
    check("async_reset_mode", 32'(u_if.set_mode), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check_time("held_at_release", 0, 0, 0);
    step(1);
    check_time("first_tick_after_reset", 0, 0, 1);
    check("first_tick_pulse", 32'(u_if.sec_pulse), 32'd1);
    u_if.h_button = 1'b0;
    step(1);
    u_if.h_button = 1'b1;
    step(1);
    u_if.h_button = 1'b0;
    check_time("h_after_refall", 1, 0, 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
